imm_inst_encoder: RTL and testbench
===================================

// Module: imm_inst_encoder
// PURPOSE
//  Inverse of ImmGen: packs opcode/funct/register fields and a full 32-bit
//  immediate into one RV32I instruction word, placing the immediate bits in
//  the I/S/B/U/J positions for that opcode. Two-stage valid/ready pipeline
//  with immediate range checking and an address counter.
//  Feeds the instruction-memory loader, which writes programs before the
//  five-stage pipeline runs. Also produces encoded vectors for ImmGen benches.
// PARAMETERS
//  BASE_ADDR  32'h0000_0000  byte address of first emitted word
//  DEPTH      256            words before imem_addr wraps to BASE_ADDR (>=2)
// PORTS
//  clk        in   1   clock, rising edge
//  rst_n      in   1   asynchronous active-low reset
//  flush      in   1   synchronous clear of pipeline and address counter
//  in_valid   in   1   input fields valid
//  in_ready   out  1   input accepted when in_valid && in_ready
//  opcode     in   7   riscv.v opcode constants (R_Type,I_Type,Il_Type,Jalr,S_Type,B_Type,lui,auipc,Jal)
//  funct3     in   3   placed at [14:12]; ignored for lui/auipc/Jal
//  funct7     in   7   placed at [31:25] for R_Type only
//  rd,rs1,rs2 in   5   register fields; each is placed only where the format has it
//  imm        in   32  immediate as a full signed byte value (the ImmGen output value)
//  out_valid  out  1   encoded word valid
//  out_ready  in   1   downstream accepts when out_valid && out_ready
//  instr      out  32  encoded instruction
//  imem_addr  out  32  byte address for instr
//  imm_err    out  1   word could not be encoded; instr forced to NOP
//  wrap       out  1   1-cycle pulse when the counter wraps after DEPTH words
// BEHAVIOUR
//  Reset/flush: out_valid=0, instr=0, imm_err=0, wrap=0, imem_addr=BASE_ADDR,
//   both stage valids cleared. in_ready=1 the cycle after reset. flush wins over
//   any same-cycle handshake, and the input offered in a flush cycle is dropped.
//  S1 (check): registers the fields and computes err. Range rules:
//   I/Il/Jalr/S: imm in [-2048,2047]; B: [-4096,4094] and imm[0]==0;
//   Jal: [-2^20,2^20-2] and imm[0]==0; lui/auipc: imm[11:0]==0 (encode imm[31:12]);
//   R: imm ignored. Unknown opcode also sets err.
//  S2 (pack/output): instr = format-packed word. If err, instr=32'h0000_0013 and
//   imm_err=1; the address still advances so positions are preserved.
//  Handshake: each stage loads when empty or when its contents move on the same
//   cycle. in_ready = !s1_v || (s1_v && (!s2_v || out_ready)), combinational from
//   out_ready. Throughput is 1 word per cycle. Latency is 2 cycles from accept to
//   out_valid with no stall.
//  Stall: while out_valid && !out_ready, instr, imem_addr and imm_err stay stable
//   and no data is lost.
//  Counter: on an output handshake imem_addr += 4. The handshake that emits word
//   index DEPTH-1 loads BASE_ADDR and pulses wrap=1 for that one cycle.
//  All arithmetic is 32-bit unsigned, and address overflow beyond 32 bits is
//   ignored.
// TESTING
//  Jalr rd=0 rs1=0 f3=0 imm=2 -> instr 32'h0020_0067, imm_err=0, addr BASE+0
//  B_Type rs1=1 rs2=2 f3=0 imm=34 -> 32'h0220_8163
//  lui rd=0 imm=4096 -> 32'h0000_1037; Jal rd=0 imm=4096 -> 32'h0000_106F
//  B_Type imm=35 (odd), then I_Type imm=2048 -> both 32'h0000_0013, imm_err=1,
//   and the address advances by 4 each
//  Back-to-back stream with out_ready low 3 cycles mid-stream -> outputs held,
//   in_ready=0 once both stages are full, no loss or duplication, order preserved
//  DEPTH=4 with 5 words -> addrs 0,4,8,C,0, wrap on 4th handshake; rst_n low
//   mid-stream -> all outputs at reset values immediately (async)

Source files
------------

// File: rtl/imm_inst_encoder.sv
// Packs RV32I fields plus a full signed immediate into one instruction word.
// Stage 1 latches fields and range-checks the immediate; stage 2 packs and emits with an address.
module imm_inst_encoder #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEPTH     = 256
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] instr,
  output logic [31:0] imem_addr,
  output logic        imm_err,
  output logic        wrap
);

  typedef enum logic [6:0] {
    OP_R     = 7'b0110011,
    OP_I     = 7'b0010011,
    OP_IL    = 7'b0000011,
    OP_JALR  = 7'b1100111,
    OP_S     = 7'b0100011,
    OP_B     = 7'b1100011,
    OP_LUI   = 7'b0110111,
    OP_AUIPC = 7'b0010111,
    OP_JAL   = 7'b1101111
  } opcode_e;

  localparam int unsigned CW   = $clog2(DEPTH);
  localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);
  localparam logic [31:0] NOP  = 32'h0000_0013;

  logic        s1_v_q, s1_v_d, s2_v_q, s2_v_d;
  logic [6:0]  op_q, op_d, f7_q, f7_d;
  logic [2:0]  f3_q, f3_d;
  logic [4:0]  rd_q, rd_d, rs1_q, rs1_d, rs2_q, rs2_d;
  logic [31:0] imm_q, imm_d;
  logic        err1_q, err1_d, err2_q, err2_d;
  logic [31:0] instr_q, instr_d, addr_q, addr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic        in_fire, s2_load, out_fire, err_in;
  logic [31:0] packed_w;

  assign in_ready  = !s1_v_q || !s2_v_q || out_ready;
  assign in_fire   = in_valid && in_ready;
  assign s2_load   = s1_v_q && (!s2_v_q || out_ready);
  assign out_fire  = s2_v_q && out_ready;
  assign out_valid = s2_v_q;
  assign instr     = instr_q;
  assign imem_addr = addr_q;
  assign imm_err   = err2_q;
  assign wrap      = out_fire && !flush && (cnt_q == LAST);

  always_comb begin
    err_in = 1'b0;
    case (opcode)
      OP_R:                    err_in = 1'b0;
      OP_I, OP_IL, OP_JALR, OP_S:
        err_in = !(($signed(imm) >= -32'sd2048) && ($signed(imm) <= 32'sd2047));
      OP_B:
        err_in = !(($signed(imm) >= -32'sd4096) && ($signed(imm) <= 32'sd4094)) || imm[0];
      OP_JAL:
        err_in = !(($signed(imm) >= -32'sd1048576) && ($signed(imm) <= 32'sd1048574)) || imm[0];
      OP_LUI, OP_AUIPC:        err_in = (imm[11:0] != 12'd0);
      default:                 err_in = 1'b1;
    endcase
  end

  always_comb begin
    packed_w = NOP;
    case (op_q)
      OP_R:                 packed_w = {f7_q, rs2_q, rs1_q, f3_q, rd_q, op_q};
      OP_I, OP_IL, OP_JALR: packed_w = {imm_q[11:0], rs1_q, f3_q, rd_q, op_q};
      OP_S:                 packed_w = {imm_q[11:5], rs2_q, rs1_q, f3_q, imm_q[4:0], op_q};
      OP_B:                 packed_w = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, f3_q,
                                        imm_q[4:1], imm_q[11], op_q};
      OP_LUI, OP_AUIPC:     packed_w = {imm_q[31:12], rd_q, op_q};
      OP_JAL:               packed_w = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12],
                                        rd_q, op_q};
      default:              packed_w = NOP;
    endcase
    if (err1_q) packed_w = NOP;
  end

  always_comb begin
    s1_v_d = s1_v_q;  s2_v_d = s2_v_q;
    op_d = op_q;  f3_d = f3_q;  f7_d = f7_q;
    rd_d = rd_q;  rs1_d = rs1_q;  rs2_d = rs2_q;
    imm_d = imm_q;  err1_d = err1_q;  err2_d = err2_q;
    instr_d = instr_q;  addr_d = addr_q;  cnt_d = cnt_q;
    if (flush) begin
      s1_v_d  = 1'b0;
      s2_v_d  = 1'b0;
      instr_d = '0;
      err2_d  = 1'b0;
      addr_d  = BASE_ADDR;
      cnt_d   = '0;
    end else begin
      if (in_fire) begin
        s1_v_d = 1'b1;
        op_d = opcode;  f3_d = funct3;  f7_d = funct7;
        rd_d = rd;  rs1_d = rs1;  rs2_d = rs2;
        imm_d = imm;  err1_d = err_in;
      end else if (s2_load) begin
        s1_v_d = 1'b0;
      end
      if (s2_load) begin
        s2_v_d  = 1'b1;
        instr_d = packed_w;
        err2_d  = err1_q;
      end else if (out_fire) begin
        s2_v_d = 1'b0;
      end
      // Errored words still consume an address slot so later words keep their positions.
      if (out_fire) begin
        if (cnt_q == LAST) begin
          addr_d = BASE_ADDR;
          cnt_d  = '0;
        end else begin
          addr_d = addr_q + 32'd4;
          cnt_d  = cnt_q + CW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_v_q <= 1'b0;  s2_v_q <= 1'b0;
      op_q <= '0;  f3_q <= '0;  f7_q <= '0;
      rd_q <= '0;  rs1_q <= '0;  rs2_q <= '0;
      imm_q <= '0;  err1_q <= 1'b0;  err2_q <= 1'b0;
      instr_q <= '0;  addr_q <= BASE_ADDR;  cnt_q <= '0;
    end else begin
      s1_v_q <= s1_v_d;  s2_v_q <= s2_v_d;
      op_q <= op_d;  f3_q <= f3_d;  f7_q <= f7_d;
      rd_q <= rd_d;  rs1_q <= rs1_d;  rs2_q <= rs2_d;
      imm_q <= imm_d;  err1_q <= err1_d;  err2_q <= err2_d;
      instr_q <= instr_d;  addr_q <= addr_d;  cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_imm_inst_encoder.sv
// Bench for imm_inst_encoder: arithmetic encoding model plus scoreboard, checked every cycle.
module tb_imm_inst_encoder;
  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int unsigned DEPTH = 4;

  localparam logic [6:0] R_T = 7'h33, I_T = 7'h13, IL_T = 7'h03, JALR = 7'h67, S_T = 7'h23,
                         B_T = 7'h63, LUI = 7'h37, AUIPC = 7'h17, JAL = 7'h6F;

  typedef struct {
    logic [6:0] op; logic [2:0] f3; logic [6:0] f7;
    logic [4:0] rd; logic [4:0] rs1; logic [4:0] rs2; logic [31:0] imm;
  } vec_t;

  logic clk = 0, rst_n = 0, flush = 0, in_valid = 0, out_ready = 1;
  logic in_ready, out_valid, imm_err, wrap;
  logic [6:0] opcode = '0, funct7 = '0;
  logic [2:0] funct3 = '0;
  logic [4:0] rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0, instr, imem_addr;

  int tests = 0, fails = 0;
  logic [32:0] q[$];
  logic [31:0] exp_addr = BASE;
  int idx = 0;
  vec_t vecs[15];

  imm_inst_encoder #(.BASE_ADDR(BASE), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .funct3(funct3), .funct7(funct7), .rd(rd), .rs1(rs1), .rs2(rs2),
    .imm(imm), .out_valid(out_valid), .out_ready(out_ready), .instr(instr),
    .imem_addr(imem_addr), .imm_err(imm_err), .wrap(wrap));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic longint unsigned fld(input longint unsigned val, input int pos);
    return val << pos;
  endfunction

  function automatic longint unsigned bits(input logic [31:0] v, input int hi, input int lo);
    longint unsigned x;
    x = 64'(v);
    return (x >> lo) & ((64'd1 << (hi - lo + 1)) - 64'd1);
  endfunction

  // Returns {err, word}; ranges are checked on the signed value, fields placed by arithmetic.
  function automatic logic [32:0] model(input vec_t x);
    longint v;
    longint unsigned w;
    bit ok;
    v  = longint'($signed(x.imm));
    ok = 1;
    w  = 0;
    case (x.op)
      R_T: w = fld(x.op,0) + fld(x.rd,7) + fld(x.f3,12) + fld(x.rs1,15) + fld(x.rs2,20)
               + fld(x.f7,25);
      I_T, IL_T, JALR: begin
        ok = (v >= -2048) && (v <= 2047);
        w  = fld(x.op,0) + fld(x.rd,7) + fld(x.f3,12) + fld(x.rs1,15) + fld(bits(x.imm,11,0),20);
      end
      S_T: begin
        ok = (v >= -2048) && (v <= 2047);
        w  = fld(x.op,0) + fld(bits(x.imm,4,0),7) + fld(x.f3,12) + fld(x.rs1,15)
             + fld(x.rs2,20) + fld(bits(x.imm,11,5),25);
      end
      B_T: begin
        ok = (v >= -4096) && (v <= 4094) && (v % 2 == 0);
        w  = fld(x.op,0) + fld(bits(x.imm,11,11),7) + fld(bits(x.imm,4,1),8) + fld(x.f3,12)
             + fld(x.rs1,15) + fld(x.rs2,20) + fld(bits(x.imm,10,5),25) + fld(bits(x.imm,12,12),31);
      end
      LUI, AUIPC: begin
        ok = (bits(x.imm,11,0) == 0);
        w  = fld(x.op,0) + fld(x.rd,7) + fld(bits(x.imm,31,12),12);
      end
      JAL: begin
        ok = (v >= -(64'sd1 <<< 20)) && (v <= (64'sd1 <<< 20) - 2) && (v % 2 == 0);
        w  = fld(x.op,0) + fld(x.rd,7) + fld(bits(x.imm,19,12),12) + fld(bits(x.imm,11,11),20)
             + fld(bits(x.imm,10,1),21) + fld(bits(x.imm,20,20),31);
      end
      default: ok = 0;
    endcase
    if (!ok) w = 64'h13;
    return {!ok, w[31:0]};
  endfunction

  function automatic vec_t mk(input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [4:0] rd_i, input logic [4:0] rs1_i,
                              input logic [4:0] rs2_i, input logic [31:0] imm_i);
    vec_t x;
    x.op = op; x.f3 = f3; x.f7 = f7; x.rd = rd_i; x.rs1 = rs1_i; x.rs2 = rs2_i; x.imm = imm_i;
    return x;
  endfunction

  function automatic vec_t cur_in();
    return mk(opcode, funct3, funct7, rd, rs1, rs2, imm);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      logic [32:0] e;
      chk("in_ready", {31'd0, in_ready}, {31'd0, (q.size() < 2) || out_ready});
      if (out_valid) begin
        if (q.size() == 0) chk("out_valid_unexpected", {31'd0, out_valid}, 32'd0);
        else begin
          e = q[0];
          chk("instr", instr, e[31:0]);
          chk("imm_err", {31'd0, imm_err}, {31'd0, e[32]});
          chk("imem_addr", imem_addr, exp_addr);
        end
      end
      chk("wrap", {31'd0, wrap},
          {31'd0, out_valid && out_ready && !flush && (idx == int'(DEPTH) - 1)});
      if (flush) begin
        q.delete();
        exp_addr = BASE;
        idx = 0;
      end else begin
        if (out_valid && out_ready && q.size() > 0) begin
          void'(q.pop_front());
          if (idx == int'(DEPTH) - 1) begin idx = 0; exp_addr = BASE; end
          else begin idx++; exp_addr = exp_addr + 32'd4; end
        end
        if (in_valid && in_ready) q.push_back(model(cur_in()));
      end
    end
  end

  task automatic send(input vec_t x);
    int n;
    opcode = x.op; funct3 = x.f3; funct7 = x.f7; rd = x.rd; rs1 = x.rs1; rs2 = x.rs2;
    imm = x.imm; in_valid = 1;
    n = 0;
    do begin @(negedge clk); n++; end while (!in_ready && n < 50);
    if (!in_ready) chk("send_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() > 0 && n < 100) begin @(negedge clk); n++; end
    chk("drain", q.size(), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_instr"}, instr, 32'd0);
    chk({tag, "_addr"}, imem_addr, BASE);
    chk({tag, "_imm_err"}, {31'd0, imm_err}, 32'd0);
    chk({tag, "_wrap"}, {31'd0, wrap}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "timeout");
  end

  initial begin
    logic [32:0] m;
    vec_t v0;
    // Model pinned against hand-encoded words.
    m = model(mk(JALR, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2));      chk("pin_jalr", m[31:0], 32'h0020_0067);
    m = model(mk(B_T, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd34));      chk("pin_b", m[31:0], 32'h0220_8163);
    m = model(mk(LUI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4096));    chk("pin_lui", m[31:0], 32'h0000_1037);
    m = model(mk(JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4096));    chk("pin_jal", m[31:0], 32'h0000_106F);
    m = model(mk(S_T, 3'd2, 7'd0, 5'd0, 5'd2, 5'd3, -32'sd4));     chk("pin_sw", m[31:0], 32'hFE31_2E23);
    m = model(mk(B_T, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd35));      chk("pin_b_odd", m, 33'h1_0000_0013);
    m = model(mk(I_T, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2048));    chk("pin_i_big", m, 33'h1_0000_0013);

    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    #1 chk_reset_vals("reset");
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;

    // First word: latency and a literal expectation straight off the pins.
    send(mk(JALR, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2));
    chk("lat_not_yet", {31'd0, out_valid}, 32'd0);
    @(posedge clk); #1;
    chk("lat_valid", {31'd0, out_valid}, 32'd1);
    chk("first_instr", instr, 32'h0020_0067);
    chk("first_addr", imem_addr, BASE);
    send(mk(B_T, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd34));
    send(mk(LUI, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4096));
    send(mk(JAL, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd4096));
    send(mk(B_T, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd35));
    send(mk(I_T, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd2048));
    drain();

    vecs[0]  = mk(R_T,   3'd0, 7'h20, 5'd5,  5'd6,  5'd7,  32'd123);
    vecs[1]  = mk(S_T,   3'd2, 7'd0,  5'd0,  5'd2,  5'd3,  -32'sd4);
    vecs[2]  = mk(AUIPC, 3'd0, 7'd0,  5'd1,  5'd0,  5'd0,  32'h1234_5000);
    vecs[3]  = mk(IL_T,  3'd2, 7'd0,  5'd4,  5'd5,  5'd0,  -32'sd2048);
    vecs[4]  = mk(I_T,   3'd0, 7'd0,  5'd1,  5'd1,  5'd0,  32'd2047);
    vecs[5]  = mk(I_T,   3'd0, 7'd0,  5'd1,  5'd1,  5'd0,  -32'sd2049);
    vecs[6]  = mk(B_T,   3'd1, 7'd0,  5'd0,  5'd8,  5'd9,  -32'sd4096);
    vecs[7]  = mk(B_T,   3'd5, 7'd0,  5'd0,  5'd8,  5'd9,  32'd4094);
    vecs[8]  = mk(B_T,   3'd0, 7'd0,  5'd0,  5'd8,  5'd9,  32'd4096);
    vecs[9]  = mk(JAL,   3'd0, 7'd0,  5'd1,  5'd0,  5'd0,  -32'sd1048576);
    vecs[10] = mk(JAL,   3'd0, 7'd0,  5'd1,  5'd0,  5'd0,  32'd1048574);
    vecs[11] = mk(JAL,   3'd0, 7'd0,  5'd1,  5'd0,  5'd0,  32'd1048576);
    vecs[12] = mk(LUI,   3'd0, 7'd0,  5'd2,  5'd0,  5'd0,  32'h0000_0800);
    vecs[13] = mk(7'h7F, 3'd0, 7'd0,  5'd2,  5'd0,  5'd0,  32'd0);
    vecs[14] = mk(JALR,  3'd0, 7'd0,  5'd31, 5'd31, 5'd0,  -32'sd1);

    fork
      begin
        for (int i = 0; i < 15; i++) send(vecs[i]);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        @(posedge clk);
        #1 out_ready = 1;
      end
    join
    drain();

    // Flush with a full pipeline and a same-cycle input offer.
    out_ready = 0;
    v0 = mk(I_T, 3'd0, 7'd0, 5'd3, 5'd3, 5'd0, 32'd7);
    send(v0);
    send(v0);
    in_valid = 1; flush = 1;
    @(posedge clk); #1;
    flush = 0; in_valid = 0;
    chk_reset_vals("flush");
    out_ready = 1;
    repeat (3) @(posedge clk);
    #1 chk("flush_dropped", {31'd0, out_valid}, 32'd0);
    send(mk(AUIPC, 3'd0, 7'd0, 5'd9, 5'd0, 5'd0, 32'hFFFF_F000));
    drain();

    // Asynchronous reset with words held in both stages.
    out_ready = 0;
    send(v0);
    send(v0);
    #2;
    chk("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    rst_n = 0;
    #1 chk_reset_vals("async_rst");
    q.delete();
    exp_addr = BASE;
    idx = 0;
    @(posedge clk); #1;
    rst_n = 1;
    out_ready = 1;
    send(mk(S_T, 3'd0, 7'd0, 5'd0, 5'd1, 5'd2, 32'd2047));
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
